// File: rtl/switch_peripheral.sv
`default_nettype none
// ============================================================================
//  Module   : switch_peripheral
//  Purpose  : Debounced 16-bit slide-switch peripheral on a shared 8-bit bus.
//             Each switch is synchronised, then debounced by sampling on a
//             slow tick. A level commits only after two consecutive ticks
//             agree. Committed changes set sticky change flags that are
//             cleared by writing 1. A change on a masked bit raises a level
//             interrupt, which is held until acknowledged.
//  Ports    : CLK                  - sole clock (rising edge)
//             RESET                - synchronous active-high reset
//             BUS_DATA     [7:0]   - shared data bus, driven only for own reads
//             BUS_ADDR     [7:0]   - shared address bus
//             BUS_WE               - 1 = write, 0 = read
//             SW          [15:0]   - raw asynchronous switch levels
//             BUS_INTERRUPT_RAISE  - level interrupt request
//             BUS_INTERRUPT_ACK    - one-cycle acknowledge
//  Register window (offset from BASE_ADDR):
//             +0/+1 stable (RO), +2/+3 chg (W1C), +4/+5 mask (RW)
//  Revision : 1.0 - initial release
// ============================================================================
module switch_peripheral #(
    parameter logic [7:0] BASE_ADDR       = 8'h80,
    parameter int         DEBOUNCE_CYCLES = 1000000
) (
    input  wire logic        CLK,
    input  wire logic        RESET,
    inout  wire       [7:0]  BUS_DATA,
    input  wire logic [7:0]  BUS_ADDR,
    input  wire logic        BUS_WE,
    input  wire logic [15:0] SW,
    output logic             BUS_INTERRUPT_RAISE,
    input  wire logic        BUS_INTERRUPT_ACK
);

    localparam logic [23:0] C_TICK_LAST = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  C_WIN_SIZE  = 8'd6;

    logic [15:0] r_meta_q, r_sync_q, r_prev_q, r_stable_q, r_chg_q, r_mask_q;
    logic [23:0] r_cnt_q;
    logic [7:0]  r_rdata_q;
    logic        r_oe_q;
    logic        r_raise_q;

    logic [7:0]  w_off;
    logic        w_in_win, w_wr, w_rd, w_tick;
    logic [23:0] w_cnt_d;
    logic [15:0] w_prev_d, w_stable_d, w_stable_chg, w_chg_clr, w_chg_d, w_mask_d;
    logic [15:0] w_agree;
    logic [7:0]  w_rdata_d;
    logic        w_raise_d;

    // Modular subtraction keeps the window test correct even when the
    // window sits near the top of the address space.
    assign w_off    = BUS_ADDR - BASE_ADDR;
    assign w_in_win = (w_off < C_WIN_SIZE);
    assign w_wr     = w_in_win & BUS_WE;
    assign w_rd     = w_in_win & ~BUS_WE;
    assign w_tick   = (r_cnt_q == C_TICK_LAST);

    always_comb begin
        w_cnt_d      = w_tick ? 24'd0 : r_cnt_q + 24'd1;
        w_prev_d     = w_tick ? r_sync_q : r_prev_q;
        // Bits whose current sample matches the previous tick's sample commit.
        w_agree      = ~(r_sync_q ^ r_prev_q);
        w_stable_d   = w_tick ? ((r_sync_q & w_agree) | (r_stable_q & ~w_agree))
                              : r_stable_q;
        w_stable_chg = w_stable_d ^ r_stable_q;

        w_chg_clr = 16'h0000;
        w_mask_d  = r_mask_q;
        if (w_wr) begin
            case (w_off[2:0])
                3'd2:    w_chg_clr = {8'h00, BUS_DATA};
                3'd3:    w_chg_clr = {BUS_DATA, 8'h00};
                3'd4:    w_mask_d  = {r_mask_q[15:8], BUS_DATA};
                3'd5:    w_mask_d  = {BUS_DATA, r_mask_q[7:0]};
                default: ;
            endcase
        end
        // A fresh change wins over a same-cycle write-1-clear.
        w_chg_d = (r_chg_q & ~w_chg_clr) | w_stable_chg;

        // Edge-triggered: only a change of stable, never mask/chg state,
        // raises; a new event wins over a coincident acknowledge.
        if (|(w_stable_chg & r_mask_q)) begin
            w_raise_d = 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            w_raise_d = 1'b0;
        end else begin
            w_raise_d = r_raise_q;
        end

        case (w_off[2:0])
            3'd0:    w_rdata_d = r_stable_q[7:0];
            3'd1:    w_rdata_d = r_stable_q[15:8];
            3'd2:    w_rdata_d = r_chg_q[7:0];
            3'd3:    w_rdata_d = r_chg_q[15:8];
            3'd4:    w_rdata_d = r_mask_q[7:0];
            3'd5:    w_rdata_d = r_mask_q[15:8];
            default: w_rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_meta_q   <= 16'h0000;
            r_sync_q   <= 16'h0000;
            r_prev_q   <= 16'h0000;
            r_stable_q <= 16'h0000;
            r_chg_q    <= 16'h0000;
            r_mask_q   <= 16'h0000;
            r_cnt_q    <= 24'd0;
            r_rdata_q  <= 8'h00;
            r_oe_q     <= 1'b0;
            r_raise_q  <= 1'b0;
        end else begin
            r_meta_q   <= SW;
            r_sync_q   <= r_meta_q;
            r_prev_q   <= w_prev_d;
            r_stable_q <= w_stable_d;
            r_chg_q    <= w_chg_d;
            r_mask_q   <= w_mask_d;
            r_cnt_q    <= w_cnt_d;
            r_rdata_q  <= w_rdata_d;
            r_oe_q     <= w_rd;
            r_raise_q  <= w_raise_d;
        end
    end

    assign BUS_DATA            = r_oe_q ? r_rdata_q : 8'hzz;
    assign BUS_INTERRUPT_RAISE = r_raise_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_peripheral.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_peripheral
//  Purpose  : Directed self-checking bench for switch_peripheral with
//             DEBOUNCE_CYCLES = 4 and BASE_ADDR = 8'h80.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_switch_peripheral;

    logic        CLK = 1'b0;
    logic        RESET;
    wire  [7:0]  BUS_DATA;
    logic [7:0]  BUS_ADDR;
    logic        BUS_WE;
    logic [15:0] SW;
    logic        BUS_INTERRUPT_RAISE;
    logic        BUS_INTERRUPT_ACK;

    logic        r_tb_oe;
    logic [7:0]  r_tb_data;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    assign BUS_DATA = r_tb_oe ? r_tb_data : 8'hzz;

    always #5 CLK = ~CLK;

    // Edge count since reset; the debounce tick fires on edges where cyc%4 becomes 0.
    always @(posedge CLK) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    switch_peripheral #(
        .BASE_ADDR       (8'h80),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .BUS_DATA            (BUS_DATA),
        .BUS_ADDR            (BUS_ADDR),
        .BUS_WE              (BUS_WE),
        .SW                  (SW),
        .BUS_INTERRUPT_RAISE (BUS_INTERRUPT_RAISE),
        .BUS_INTERRUPT_ACK   (BUS_INTERRUPT_ACK)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR  = a;
        BUS_WE    = 1'b1;
        r_tb_oe   = 1'b1;
        r_tb_data = d;
        step();
        BUS_WE    = 1'b0;
        r_tb_oe   = 1'b0;
        BUS_ADDR  = 8'h00;
    endtask

    // Address cycle, then the data cycle (sampled), then a turnaround cycle.
    task automatic bus_read(input logic [7:0] a, output logic [7:0] d,
                            output logic oe_data, output logic oe_after);
        BUS_ADDR = a;
        BUS_WE   = 1'b0;
        step();
        d        = BUS_DATA;
        oe_data  = dut.r_oe_q;
        BUS_ADDR = 8'h00;
        step();
        oe_after = dut.r_oe_q;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic oe1, oe2;
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) $display("FAIL rst_raise: got %b want 0", BUS_INTERRUPT_RAISE);
        else n_pass++;
        n_checks++;
        if (dut.r_oe_q !== 1'b0) $display("FAIL rst_hiz: drive enable got %b want 0", dut.r_oe_q);
        else n_pass++;
        bus_read(8'h80, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h00 || oe1 !== 1'b1) $display("FAIL rst_rd80: got %h oe %b want 00 oe 1", d, oe1);
        else n_pass++;
        n_checks++;
        if (oe2 !== 1'b0) $display("FAIL rst_rd80_hiz: drive enable got %b want 0", oe2);
        else n_pass++;
        for (int a = 8'h81; a <= 8'h85; a++) begin
            bus_read(8'(a), d, oe1, oe2);
            n_checks++;
            if (d !== 8'h00 || oe1 !== 1'b1) $display("FAIL rst_rd%h: got %h oe %b want 00 oe 1", a, d, oe1);
            else n_pass++;
        end
    endtask

    task automatic test_addr_decode;
        logic [7:0] d;
        logic oe1, oe2;
        bus_write(8'h80, 8'hFF);
        bus_write(8'h81, 8'hFF);
        bus_write(8'h86, 8'hFF);
        bus_write(8'h7F, 8'hFF);
        bus_read(8'h80, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h00) $display("FAIL ro_stable: got %h want 00", d);
        else n_pass++;
        bus_read(8'h84, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h00) $display("FAIL outside_wr_mask: got %h want 00", d);
        else n_pass++;
        bus_read(8'h86, d, oe1, oe2);
        n_checks++;
        if (oe1 !== 1'b0) $display("FAIL outside_rd_hiz: drive enable got %b want 0", oe1);
        else n_pass++;
        bus_read(8'h7F, d, oe1, oe2);
        n_checks++;
        if (oe1 !== 1'b0) $display("FAIL below_rd_hiz: drive enable got %b want 0", oe1);
        else n_pass++;
    endtask

    task automatic test_glitch;
        logic [7:0] d;
        logic oe1, oe2;
        SW[3] = 1'b1;
        step(3);
        SW[3] = 1'b0;
        step(12);
        bus_read(8'h80, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h00) $display("FAIL glitch_stable: got %h want 00", d);
        else n_pass++;
        bus_read(8'h82, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h00) $display("FAIL glitch_chg: got %h want 00", d);
        else n_pass++;
    endtask

    task automatic test_debounce;
        logic [7:0] d;
        logic oe1, oe2;
        SW[3] = 1'b1;
        step(10);
        bus_read(8'h80, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h08) $display("FAIL deb_stable: got %h want 08", d);
        else n_pass++;
        bus_read(8'h82, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h08) $display("FAIL deb_chg: got %h want 08", d);
        else n_pass++;
        bus_read(8'h81, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h00) $display("FAIL deb_stable_hi: got %h want 00", d);
        else n_pass++;
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) $display("FAIL deb_noirq: got %b want 0", BUS_INTERRUPT_RAISE);
        else n_pass++;
    endtask

    task automatic test_irq;
        logic [7:0] d;
        logic oe1, oe2;
        bus_write(8'h84, 8'h01);
        SW[0] = 1'b1;
        step(10);
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) $display("FAIL irq_raise: got %b want 1", BUS_INTERRUPT_RAISE);
        else n_pass++;
        step(3);
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) $display("FAIL irq_hold: got %b want 1", BUS_INTERRUPT_RAISE);
        else n_pass++;
        BUS_INTERRUPT_ACK = 1'b1;
        step();
        BUS_INTERRUPT_ACK = 1'b0;
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) $display("FAIL irq_ack: got %b want 0", BUS_INTERRUPT_RAISE);
        else n_pass++;
        BUS_INTERRUPT_ACK = 1'b1;
        step();
        BUS_INTERRUPT_ACK = 1'b0;
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) $display("FAIL irq_idle_ack: got %b want 0", BUS_INTERRUPT_RAISE);
        else n_pass++;
        bus_read(8'h82, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h09) $display("FAIL irq_chg: got %h want 09", d);
        else n_pass++;
        bus_write(8'h82, 8'h01);
        bus_read(8'h82, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h08) $display("FAIL w1c_chg: got %h want 08", d);
        else n_pass++;
        // Unmasking a bit whose chg is already set must not raise.
        bus_write(8'h84, 8'h09);
        step(3);
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) $display("FAIL mask_level: got %b want 0", BUS_INTERRUPT_RAISE);
        else n_pass++;
        bus_read(8'h84, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h09) $display("FAIL mask_rd: got %h want 09", d);
        else n_pass++;
    endtask

    task automatic test_ack_collision;
        logic [7:0] d;
        logic oe1, oe2;
        int guard;
        bus_write(8'h85, 8'h01);
        SW[0] = 1'b0;
        step(10);
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) $display("FAIL coll_pre_raise: got %b want 1", BUS_INTERRUPT_RAISE);
        else n_pass++;
        guard = 0;
        while ((cyc % 4) != 0 && guard < 4) begin
            step();
            guard++;
        end
        n_checks++;
        if ((cyc % 4) != 0) $display("FAIL coll_align: cycle phase got %0d want 0", cyc % 4);
        else n_pass++;
        // sync at +2, first tick at +4, commit tick at +8.
        SW[8] = 1'b1;
        step(7);
        BUS_INTERRUPT_ACK = 1'b1;
        step();
        BUS_INTERRUPT_ACK = 1'b0;
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) $display("FAIL coll_event_wins: got %b want 1", BUS_INTERRUPT_RAISE);
        else n_pass++;
        step();
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) $display("FAIL coll_hold: got %b want 1", BUS_INTERRUPT_RAISE);
        else n_pass++;
        bus_read(8'h83, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h01) $display("FAIL coll_chg_hi: got %h want 01", d);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic oe1, oe2;
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) $display("FAIL rmid_pre_raise: got %b want 1", BUS_INTERRUPT_RAISE);
        else n_pass++;
        SW = 16'hFFFF;
        step(5);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) $display("FAIL rmid_raise: got %b want 0", BUS_INTERRUPT_RAISE);
        else n_pass++;
        bus_read(8'h80, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h00) $display("FAIL rmid_stable: got %h want 00", d);
        else n_pass++;
        bus_read(8'h82, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h00) $display("FAIL rmid_chg: got %h want 00", d);
        else n_pass++;
        bus_read(8'h84, d, oe1, oe2);
        n_checks++;
        if (d !== 8'h00) $display("FAIL rmid_mask: got %h want 00", d);
        else n_pass++;
        step(6);
        bus_read(8'h80, d, oe1, oe2);
        n_checks++;
        if (d !== 8'hFF) $display("FAIL rmid_stable_lo: got %h want ff", d);
        else n_pass++;
        bus_read(8'h81, d, oe1, oe2);
        n_checks++;
        if (d !== 8'hFF) $display("FAIL rmid_stable_hi: got %h want ff", d);
        else n_pass++;
        bus_read(8'h82, d, oe1, oe2);
        n_checks++;
        if (d !== 8'hFF) $display("FAIL rmid_chg_lo: got %h want ff", d);
        else n_pass++;
        bus_read(8'h83, d, oe1, oe2);
        n_checks++;
        if (d !== 8'hFF) $display("FAIL rmid_chg_hi: got %h want ff", d);
        else n_pass++;
        n_checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) $display("FAIL rmid_noirq: got %b want 0", BUS_INTERRUPT_RAISE);
        else n_pass++;
    endtask

    initial begin
        RESET             = 1'b1;
        BUS_ADDR          = 8'h00;
        BUS_WE            = 1'b0;
        SW                = 16'h0000;
        BUS_INTERRUPT_ACK = 1'b0;
        r_tb_oe           = 1'b0;
        r_tb_data         = 8'h00;
        test_reset();
        test_addr_decode();
        test_glitch();
        test_debounce();
        test_irq();
        test_ack_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/switch_peripheral.md
SWITCH_PERIPHERAL -- requirements
Module: switch_peripheral

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h80: base of a 6-byte register window, BASE_ADDR+0 to +5.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: sample-tick period in CLK cycles, legal range 2 to 2^24-1.
REQ-003 SHALL have port CLK  input  1: sole clock, all state rising-edge.
REQ-004 SHALL have port RESET  input  1: synchronous, active-high reset.
REQ-005 SHALL have port BUS_DATA  inout  8: shared data bus, driven only during reads of own window, else high-Z.
REQ-006 SHALL have port BUS_ADDR  input  8: shared address bus.
REQ-007 SHALL have port BUS_WE  input  1: bus write strobe, 1 = write, 0 = read.
REQ-008 SHALL have port SW  input  16: raw asynchronous slide-switch levels.
REQ-009 SHALL have port BUS_INTERRUPT_RAISE  output  1: level interrupt request to the processor.
REQ-010 SHALL have port BUS_INTERRUPT_ACK  input  1: one-cycle acknowledge from the processor.

Function
REQ-011 SHALL pass each SW bit through a 2-flop synchronizer; the output is sync[15:0].
REQ-012 SHALL run a tick counter 0 to DEBOUNCE_CYCLES-1, wrapping to 0, and assert tick for one cycle when count = DEBOUNCE_CYCLES-1.
REQ-013 SHALL on each tick sample sync into prev[15:0].
REQ-014 SHALL on each tick set stable[i] <= sync[i] wherever sync[i] == prev[i], so a level needs 2 consecutive matching ticks to commit.
REQ-015 SHALL on the cycle stable[i] changes value set chg[i] <= 1, sticky.
REQ-016 SHALL clear chg[i] on a bus write of 1 to bit i of BASE+2 (bits 7:0) or BASE+3 (bits 15:8); written 0 bits are unaffected.
REQ-017 SHALL give set priority over clear: a same-cycle stable change and write-1-clear on bit i leaves chg[i] = 1.
REQ-018 SHALL write mask[7:0] at BASE+4 and mask[15:8] at BASE+5.
REQ-019 SHALL ignore writes to BASE+0 and BASE+1, and ignore any address outside the window.
REQ-020 SHALL return on reads: BASE+0 stable[7:0], BASE+1 stable[15:8], BASE+2 chg[7:0], BASE+3 chg[15:8], BASE+4 mask[7:0], BASE+5 mask[15:8].
REQ-021 SHALL register read data and the drive enable: if cycle N has BUS_ADDR in window and BUS_WE = 0, BUS_DATA is driven with the register value as of cycle N during cycle N+1; otherwise it is high-Z in N+1.
REQ-022 SHALL set BUS_INTERRUPT_RAISE <= 1 on any cycle where a stable bit changes with its mask bit = 1.
REQ-023 SHALL hold RAISE until BUS_INTERRUPT_ACK = 1, which clears it on the next edge.
REQ-024 SHALL keep RAISE = 1 when ACK and a new masked event occur in the same cycle (event wins).
REQ-025 SHALL not raise an interrupt when a mask bit is written to 1 while that chg bit is already 1 (edge-triggered, not level).
REQ-026 SHALL ignore ACK while RAISE = 0.

Reset
REQ-027 SHALL on RESET = 1 at a clock edge clear the synchronizers, prev, stable, chg, mask, tick counter, read register, drive enable and RAISE to 0; BUS_DATA is high-Z from the next cycle.
REQ-028 SHALL abandon any in-progress debounce or pending interrupt on a mid-operation reset; switches held at 1 across reset re-commit after 2 ticks and set chg, with no interrupt since mask = 0.

Verification (DEBOUNCE_CYCLES = 4, BASE_ADDR = 8'h80)
REQ-029 SHALL cover: reset, SW = 16'h0000, read 8'h80 -> 8'h00 on BUS_DATA the cycle after the address, high-Z otherwise.
REQ-030 SHALL cover: SW[3] 0->1 held, mask = 0 -> stable[3] = 1 within 2 ticks + 2 sync cycles (at most 11 cycles); 8'h82 reads 8'h08; RAISE stays 0.
REQ-031 SHALL cover: SW[3] glitch high for 3 cycles -> stable and chg unchanged, reads 8'h00.
REQ-032 SHALL cover: write 8'h84 = 8'h01, toggle SW[0] -> RAISE = 1 and held until a 1-cycle ACK, 0 the cycle after; then write 8'h82 = 8'h01 -> chg[0] = 0.
REQ-033 SHALL cover: ACK coincident with a new masked change on SW[8] (8'h85 = 8'h01) -> RAISE stays 1; 8'h83 reads 8'h01.
REQ-034 SHALL cover: reset asserted mid-debounce with SW = 16'hFFFF -> all registers 0; after 2 ticks 8'h80 and 8'h81 read 8'hFF, and RAISE stays 0.
